// File: rtl/handshake_skid_pipe_if.sv
// Valid/ready bundle for handshake_skid_pipe.
// The slave modport is the pipe's view; the master modport is the surrounding logic's view.
interface handshake_skid_pipe_if #(
    parameter int VALUE_BITS = 8,
    parameter int STAGES     = 2
);
    localparam int CW = $clog2(2 * STAGES + 1);

    logic [VALUE_BITS-1:0] i_value;
    logic                  i_valid;
    logic                  o_ready;
    logic [VALUE_BITS-1:0] o_value;
    logic                  o_valid;
    logic                  i_ready;
    logic [CW-1:0]         o_count;

    modport master (
        output i_value, i_valid, i_ready,
        input  o_ready, o_value, o_valid, o_count
    );

    modport slave (
        input  i_value, i_valid, i_ready,
        output o_ready, o_value, o_valid, o_count
    );
endinterface

// File: rtl/handshake_skid_pipe.sv
// Fully registered valid/ready pipe of STAGES skid stages with occupancy count.
// HANDSHAKE_SKID_PIPE_ZERO_VALUE_EN: when defined, o_value reads '0 while o_valid is low.
module handshake_skid_pipe #(
    parameter int VALUE_BITS = 8,
    parameter int STAGES     = 2
) (
    input  logic clock,
    input  logic reset,
    handshake_skid_pipe_if.slave bus
);
    localparam int CW = $clog2(2 * STAGES + 1);

    if (STAGES < 1 || STAGES > 16) begin : g_bad_stages
        $error("handshake_skid_pipe: STAGES must be in 1..16");
    end
    if (VALUE_BITS < 1) begin : g_bad_width
        $error("handshake_skid_pipe: VALUE_BITS must be >= 1");
    end

    typedef enum logic [1:0] {
        EMPTY,
        BUSY,
        FULL
    } stage_state_e;

    stage_state_e          state_q [STAGES];
    stage_state_e          state_d [STAGES];
    logic [VALUE_BITS-1:0] main_q  [STAGES];
    logic [VALUE_BITS-1:0] main_d  [STAGES];
    logic [VALUE_BITS-1:0] skid_q  [STAGES];
    logic [VALUE_BITS-1:0] skid_d  [STAGES];
    logic [VALUE_BITS-1:0] in_val  [STAGES];
    logic [STAGES-1:0]     rdy_q;
    logic [STAGES-1:0]     rdy_d;
    logic [STAGES-1:0]     main_vld;
    logic [STAGES-1:0]     in_vld;
    logic [STAGES-1:0]     dn_rdy;
    logic [STAGES-1:0]     acc;
    logic [STAGES-1:0]     drn;
    logic [CW-1:0]         cnt_q;
    logic [CW-1:0]         cnt_d;
    logic                  up_xfer;
    logic                  dn_xfer;

    for (genvar k = 0; k < STAGES; k++) begin : g_link
        assign main_vld[k] = (state_q[k] != EMPTY);
        if (k == 0) begin : g_head
            assign in_vld[k] = bus.i_valid;
            assign in_val[k] = bus.i_value;
        end else begin : g_mid
            assign in_vld[k] = main_vld[k-1];
            assign in_val[k] = main_q[k-1];
        end
        if (k == STAGES - 1) begin : g_tail
            assign dn_rdy[k] = bus.i_ready;
        end else begin : g_body
            assign dn_rdy[k] = rdy_q[k+1];
        end
        assign acc[k] = in_vld[k] & rdy_q[k];
        assign drn[k] = main_vld[k] & dn_rdy[k];
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            state_d[k] = state_q[k];
            main_d[k]  = main_q[k];
            skid_d[k]  = skid_q[k];
            unique case (state_q[k])
                EMPTY: begin
                    if (acc[k]) begin
                        state_d[k] = BUSY;
                        main_d[k]  = in_val[k];
                    end
                end
                BUSY: begin
                    unique case (1'b1)
                        acc[k] && drn[k]: main_d[k] = in_val[k];
                        acc[k] && !drn[k]: begin
                            state_d[k] = FULL;
                            skid_d[k]  = in_val[k];
                        end
                        !acc[k] && drn[k]: state_d[k] = EMPTY;
                        default: ;
                    endcase
                end
                FULL: begin
                    if (drn[k]) begin
                        state_d[k] = BUSY;
                        main_d[k]  = skid_q[k];
                    end
                end
                default: state_d[k] = EMPTY;
            endcase
            // Ready is the registered inverse of the skid valid it will see next.
            rdy_d[k] = (state_d[k] != FULL);
        end
    end

    assign up_xfer = bus.i_valid & rdy_q[0];
    assign dn_xfer = main_vld[STAGES-1] & bus.i_ready;

    always_comb begin
        cnt_d = cnt_q;
        unique case ({up_xfer, dn_xfer})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < STAGES; k++) begin
                state_q[k] <= EMPTY;
                main_q[k]  <= '0;
                skid_q[k]  <= '0;
            end
            rdy_q <= '0;
            cnt_q <= '0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                state_q[k] <= state_d[k];
                main_q[k]  <= main_d[k];
                skid_q[k]  <= skid_d[k];
            end
            rdy_q <= rdy_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.o_ready = rdy_q[0];
    assign bus.o_valid = main_vld[STAGES-1];
    assign bus.o_count = cnt_q;
`ifdef HANDSHAKE_SKID_PIPE_ZERO_VALUE_EN
    assign bus.o_value = main_vld[STAGES-1] ? main_q[STAGES-1] : '0;
`else
    assign bus.o_value = main_q[STAGES-1];
`endif
endmodule
